// File: rtl/axi4_mult_master.sv
// ---------------------------------------------------------------------------
// axi4_mult_master
//
// AXI4-style initiator for the multiplier slave wrapper. A start pulse on the
// user port latches two SZ-bit operands. Operand A is written as one burst to
// address 0 and operand B as one burst to address 1. Each burst is followed
// by its write response. One read burst from address 0 then returns the
// 2*SZ-bit product as DSZ-bit beats, and those beats are assembled into
// result.
//
// The channel set is a reduced AXI4 subset (no len/size/id). Burst lengths
// are implied by the parameters:
//   NB = SZ/DSZ     beats per operand write burst
//   NR = 2*SZ/DSZ   beats in the product read burst
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start, a, b     user request; sampled only while idle
//   busy, done      busy in every state but IDLE; done pulses once at the end
//   result, err     assembled product and sticky error of the last transaction
//   aw*             write address channel  (awaddr, awvalid / awready)
//   w*              write data channel     (wdata, wvalid, wlast / wready)
//   b*              write response channel (bresp, bvalid / bready)
//   ar*             read address channel   (araddr, arvalid / arready)
//   r*              read data channel      (rdata, rvalid, rlast, rresp / rready)
//
// State table
//   IDLE | waiting for start; all channel outputs low
//   AW   | presenting write address (op_sel selects operand A or B)
//   W    | streaming operand beats, LSB beat first, wlast on beat NB-1
//   B    | accepting the write response for the current operand
//   AR   | presenting the read address; the slave may stall indefinitely
//   R    | collecting product beats into result
//   FIN  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module axi4_mult_master #(
  parameter int SZ  = 32,
  parameter int ASZ = 2,
  parameter int DSZ = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              start,
  input  logic [SZ-1:0]     a,
  input  logic [SZ-1:0]     b,
  output logic              busy,
  output logic              done,
  output logic [2*SZ-1:0]   result,
  output logic              err,

  output logic [ASZ-1:0]    awaddr,
  output logic              awvalid,
  input  logic              awready,

  output logic [DSZ-1:0]    wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,

  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready,

  output logic [ASZ-1:0]    araddr,
  output logic              arvalid,
  input  logic              arready,

  input  logic [DSZ-1:0]    rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast,
  input  logic              rresp
);

  localparam int NB = SZ / DSZ;
  localparam int NR = 2 * SZ / DSZ;
  // The beat counter must be able to hold NR itself, the saturation value
  // that marks surplus read beats.
  localparam int BW = $clog2(NR + 1);

  localparam logic [BW-1:0] NR_B      = BW'(NR);
  localparam logic [BW-1:0] LAST_NB_B = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              op_sel_q, op_sel_d;
  logic [SZ-1:0]     a_q, a_d;
  logic [SZ-1:0]     b_q, b_d;
  logic [2*SZ-1:0]   result_q, result_d;
  logic              err_q, err_d;

  // Handshakes are qualified by state because the matching valid/ready
  // output is asserted only in that state.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = (state_q == S_AW) && awready;
  assign w_hs  = (state_q == S_W)  && wready;
  assign b_hs  = (state_q == S_B)  && bvalid;
  assign ar_hs = (state_q == S_AR) && arready;
  assign r_hs  = (state_q == S_R)  && rvalid;

  logic [SZ-1:0] operand;
  assign operand = op_sel_q ? b_q : a_q;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      op_sel_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      op_sel_q <= op_sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_AW;
      S_AW:   if (aw_hs) state_d = S_W;
      S_W:    if (w_hs && (beat_q == LAST_NB_B)) state_d = S_B;
      S_B:    if (b_hs) state_d = op_sel_q ? S_AR : S_AW;
      S_AR:   if (ar_hs) state_d = S_R;
      S_R:    if (r_hs && rlast) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    beat_d   = beat_q;
    op_sel_d = op_sel_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          result_d = '0;
          err_d    = 1'b0;
          op_sel_d = 1'b0;
        end
      end

      S_AW: begin
        if (aw_hs) beat_d = '0;
      end

      S_W: begin
        if (w_hs) beat_d = beat_q + 1'b1;
      end

      S_B: begin
        if (b_hs) begin
          if (!bresp) err_d = 1'b1;
          if (!op_sel_q) op_sel_d = 1'b1;
        end
      end

      S_AR: begin
        if (ar_hs) beat_d = '0;
      end

      S_R: begin
        if (r_hs) begin
          if (beat_q < NR_B) begin
            for (int i = 0; i < NR; i++) begin
              if (beat_q == BW'(i)) result_d[i*DSZ +: DSZ] = rdata;
            end
          end else begin
            // Surplus beat beyond the product width: dropped and flagged.
            err_d = 1'b1;
          end
          if (beat_q != NR_B) beat_d = beat_q + 1'b1;
          if (!rresp) err_d = 1'b1;
          // rlast must coincide with beat NR-1; early or late is an error.
          if (rlast && ((beat_q + 1'b1) != NR_B)) err_d = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (Moore, decoded from the current state)
  // -------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;

    case (state_q)
      S_AW: begin
        awvalid = 1'b1;
        awaddr  = ASZ'(op_sel_q);
      end
      S_W: begin
        wvalid = 1'b1;
        wlast  = (beat_q == LAST_NB_B);
        for (int i = 0; i < NB; i++) begin
          if (beat_q == BW'(i)) wdata = operand[i*DSZ +: DSZ];
        end
      end
      S_B:   bready  = 1'b1;
      S_AR:  arvalid = 1'b1;
      S_R:   rready  = 1'b1;
      S_FIN: done    = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_axi4_mult_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_mult_master
//
// Drives axi4_mult_master against a behavioural slave that can insert
// handshake delays, a mid-burst wready gap, bad responses and an early rlast.
// The slave multiplies the operands it actually received. Expected AW
// addresses, W beats and final result/err come from hand-computed constants.
// These constants are queued when a start is issued and checked by a
// separate monitor process.
// ---------------------------------------------------------------------------
module tb_axi4_mult_master;

  localparam int SZ  = 32;
  localparam int ASZ = 2;
  localparam int DSZ = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [SZ-1:0]     a = '0;
  logic [SZ-1:0]     b = '0;
  logic              busy, done, err;
  logic [2*SZ-1:0]   result;
  logic [ASZ-1:0]    awaddr, araddr;
  logic              awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [DSZ-1:0]    wdata;
  logic              awready = 1'b0;
  logic              wready  = 1'b0;
  logic              bresp   = 1'b1;
  logic              bvalid  = 1'b0;
  logic              arready = 1'b0;
  logic [DSZ-1:0]    rdata   = '0;
  logic              rvalid  = 1'b0;
  logic              rlast   = 1'b0;
  logic              rresp   = 1'b1;

  axi4_mult_master #(.SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst),
    .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .err(err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [ASZ-1:0] aw_q[$];
  logic [8:0]     w_q[$];     // {wlast, wdata}
  logic [64:0]    res_q[$];   // {err, result}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave configuration ----------------
  int aw_delay = 0, w_stall_at = -1, w_stall_len = 0, b_delay = 0, ar_delay = 0;
  int bad_b_op = -1, bad_r_beat = -1, rlast_at = 7;
  bit r_override = 1'b0;

  // ---------------- slave state ----------------
  int aw_cnt, b_cnt, ar_cnt, w_beat, w_stall_cnt, r_idx;
  bit r_active;
  logic [ASZ-1:0] cur_addr;
  logic [7:0]  opbuf [2][4];
  logic [63:0] prod;

  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s, r_last_s;
    logic [ASZ-1:0] aw_addr_s;
    logic [7:0] w_data_s;
    logic [31:0] op_a, op_b;
    logic [63:0] sh;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; r_last_s = 0;
    aw_addr_s = '0; w_data_s = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        aw_cnt = 0; b_cnt = 0; ar_cnt = 0; w_beat = 0; w_stall_cnt = 0; r_idx = 0;
        r_active = 0; cur_addr = '0; prod = '0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 1; arready = 0;
        rvalid = 0; rlast = 0; rresp = 1; rdata = '0;
        continue;
      end
      // consequences of the handshakes that completed at this edge
      if (aw_hs) begin cur_addr = aw_addr_s; aw_cnt = 0; w_beat = 0; w_stall_cnt = 0; end
      if (w_hs) begin
        if (w_beat < 4) opbuf[cur_addr[0]][w_beat] = w_data_s;
        w_beat++;
      end
      if (b_hs) b_cnt = 0;
      if (ar_hs) begin
        ar_cnt = 0;
        op_a = {opbuf[0][3], opbuf[0][2], opbuf[0][1], opbuf[0][0]};
        op_b = {opbuf[1][3], opbuf[1][2], opbuf[1][1], opbuf[1][0]};
        prod = 64'(op_a) * 64'(op_b);
        r_active = 1; r_idx = 0;
      end
      if (r_hs) begin
        if (r_last_s) r_active = 0;
        r_idx++;
      end
      // drive this cycle
      awready = awvalid && (aw_cnt >= aw_delay);
      if (awvalid && !awready) aw_cnt++;
      if (wvalid && w_beat == w_stall_at && w_stall_cnt < w_stall_len) begin
        wready = 0; w_stall_cnt++;
      end else wready = 1;
      bvalid = bready && (b_cnt >= b_delay);
      if (bready && !bvalid) b_cnt++;
      bresp = !(int'(cur_addr) == bad_b_op);
      arready = arvalid && (ar_cnt >= ar_delay);
      if (arvalid && !arready) ar_cnt++;
      rvalid = r_active;
      sh = prod >> (r_idx * 8);
      rdata = r_override ? 8'(8'h11 * (r_idx + 1)) : sh[7:0];
      rlast = r_active && (r_idx == rlast_at);
      rresp = (r_idx != bad_r_beat);
      // handshakes that will complete at the next edge
      aw_hs = awvalid && awready; aw_addr_s = awaddr;
      w_hs  = wvalid && wready;   w_data_s = wdata;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;   r_last_s = rlast;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit p_aw, p_w, p_ar, p_done;
    logic [ASZ-1:0] p_awaddr, p_araddr;
    logic [7:0] p_wdata;
    logic p_wlast;
    logic [8:0] wexp;
    logic [64:0] rexp;
    p_aw = 0; p_w = 0; p_ar = 0; p_done = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wlast = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_aw) begin
          chk("aw_stable_valid", 64'(awvalid), 64'd1);
          chk("aw_stable_addr", 64'(awaddr), 64'(p_awaddr));
        end
        if (p_w) begin
          chk("w_stable_valid", 64'(wvalid), 64'd1);
          chk("w_stable_data", 64'(wdata), 64'(p_wdata));
          chk("w_stable_last", 64'(wlast), 64'(p_wlast));
        end
        if (p_ar) begin
          chk("ar_stable_valid", 64'(arvalid), 64'd1);
          chk("ar_stable_addr", 64'(araddr), 64'(p_araddr));
        end
        if (p_done) chk("done_one_cycle", 64'(done), 64'd0);

        if (awvalid && awready) begin
          if (aw_q.size() == 0) chk("aw_unexpected", 64'(awaddr), 64'hDEAD);
          else chk("awaddr", 64'(awaddr), 64'(aw_q.pop_front()));
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) chk("w_unexpected", 64'(wdata), 64'hDEAD);
          else begin
            wexp = w_q.pop_front();
            chk("wdata", 64'(wdata), 64'(wexp[7:0]));
            chk("wlast", 64'(wlast), 64'(wexp[8]));
          end
        end
        if (arvalid && arready) chk("araddr", 64'(araddr), 64'd0);
        if (done) begin
          done_cnt++;
          if (res_q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
          else begin
            rexp = res_q.pop_front();
            chk("result", result, rexp[63:0]);
            chk("err", 64'(err), 64'(rexp[64]));
          end
        end
      end
      p_aw = !rst && awvalid && !awready; p_awaddr = awaddr;
      p_w  = !rst && wvalid && !wready;   p_wdata = wdata; p_wlast = wlast;
      p_ar = !rst && arvalid && !arready; p_araddr = araddr;
      p_done = !rst && done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_op(input logic [31:0] op, input logic [ASZ-1:0] addr);
    aw_q.push_back(addr);
    for (int i = 0; i < 4; i++) w_q.push_back({(i == 3), op[i*8 +: 8]});
  endtask

  task automatic run_tx(input logic [31:0] ta, input logic [31:0] tb_op,
                        input logic [63:0] er, input logic ee, input bit poke);
    int base, n;
    base = done_cnt;
    push_op(ta, 2'd0);
    push_op(tb_op, 2'd1);
    res_q.push_back({ee, er});
    @(posedge clk); #1;
    a = ta; b = tb_op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared_on_start", 64'(err), 64'd0);
    if (poke) begin
      n = 0;
      while (!rready && n < 500) begin @(posedge clk); #1; n++; end
      chk("reached_r_state", 64'(rready), 64'd1);
      a = 32'hFF; b = 32'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == base && n < 2000) begin @(posedge clk); n++; end
    if (done_cnt == base) chk("done_timeout", 64'(done_cnt - base), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("single_done", 64'(done_cnt - base), 64'd1);
    chk("idle_after", 64'(busy), 64'd0);
    chk("result_held", result, er);
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, wlast, bready, arvalid, rready}), 64'd0);
    chk("rst_addr_data", 64'({awaddr, araddr, wdata}), 64'd0);
    rst = 1'b0;

    // basic, zero-wait slave
    run_tx(32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1'b0, 1'b0);

    // backpressure on every channel
    aw_delay = 3; w_stall_at = 2; w_stall_len = 2; b_delay = 4; ar_delay = 5;
    run_tx(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0);
    aw_delay = 0; w_stall_at = -1; w_stall_len = 0; b_delay = 0; ar_delay = 0;

    // bad write response on operand B, then a clean run clears err
    bad_b_op = 1;
    run_tx(32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 1'b1, 1'b0);
    bad_b_op = -1;
    run_tx(32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 1'b0, 1'b0);

    // bad read response on beat 3, then a clean run
    bad_r_beat = 3;
    run_tx(32'h0000_0100, 32'h0000_0100, 64'h0000_0000_0001_0000, 1'b1, 1'b0);
    bad_r_beat = -1;
    run_tx(32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006, 1'b0, 1'b0);

    // early rlast on beat 5 of 8 with a fixed data pattern
    r_override = 1'b1; rlast_at = 4;
    run_tx(32'h0000_0009, 32'h0000_0009, 64'h0000_0055_4433_2211, 1'b1, 1'b0);
    r_override = 1'b0; rlast_at = 7;

    // reset during beat 2 of operand A
    push_op(32'hAABB_CCDD, 2'd0);
    @(posedge clk); #1;
    a = 32'hAABB_CCDD; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    #1;
    while (!(wvalid && cur_addr == 2'd0 && w_beat == 2) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    chk("reached_w_beat2", 64'(w_beat), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wvalid", 64'(wvalid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_wdata", 64'(wdata), 64'd0);
    rst = 1'b0;
    aw_q.delete(); w_q.delete(); res_q.delete();
    run_tx(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0, 1'b0);

    // start pulsed while in R is ignored
    run_tx(32'h0000_0010, 32'h0000_0020, 64'h0000_0000_0000_0200, 1'b0, 1'b1);

    chk("queues_drained", 64'(aw_q.size() + w_q.size() + res_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
